// File: rtl/spi_flash_dma.sv
// spi_flash_dma: CPU-programmed loader that reads 16-bit words from SPI flash with a
// standard READ (0x03) command and pushes each word to the graphics memory arbiter
// over a valid/ready write channel.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   ADDRESS, DATA_IN, WR      register window write side (0 FADDR_LO, 1 FADDR_HI, 2 DEST,
//                             3 COUNT, 4 CTRL/STATUS)
//   DATA_OUT                  registered read data for ADDRESS (1-cycle latency)
//   SCK, MOSI, MISO, CS_N     SPI mode 0 flash interface
//   flash_dma_*               word write channel toward the graphics arbiter
//   DONE                      one-cycle pulse on completion or abort
module spi_flash_dma #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ADDRESS,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  input  logic        WR,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS_N,
  output logic        flash_dma_wvalid,
  input  logic        flash_dma_wready,
  output logic [15:0] flash_dma_address,
  output logic [15:0] flash_dma_data,
  output logic        DONE
);

  localparam logic [7:0] DivMax = 8'(CLK_DIV);

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StCmd,
    StData,
    StWaitWr,
    StCsHold
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] faddr_lo_q, faddr_lo_d;
  logic [7:0]  faddr_hi_q, faddr_hi_d;
  logic [15:0] dest_q, dest_d;
  logic [15:0] count_q, count_d;
  logic        done_flag_q, done_flag_d;
  logic        done_q, done_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] waddr_q, waddr_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic [15:0] rdata_q, rdata_d;

  logic busy, div_wrap, ctrl_wr, go, abort;

  always_comb begin
    state_d     = state_q;
    faddr_lo_d  = faddr_lo_q;
    faddr_hi_d  = faddr_hi_q;
    dest_d      = dest_q;
    count_d     = count_q;
    done_flag_d = done_flag_q;
    done_d      = 1'b0;
    rem_d       = rem_q;
    waddr_d     = waddr_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    div_d       = div_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    rdata_d     = 16'h0000;

    busy     = (state_q != StIdle);
    div_wrap = (div_q == DivMax);
    ctrl_wr  = WR && (ADDRESS == 4'd4);
    go       = ctrl_wr && DATA_IN[0];
    abort    = ctrl_wr && DATA_IN[1];

    // Configuration is frozen while a transfer runs.
    if (WR && !busy) begin
      case (ADDRESS)
        4'd0:    faddr_lo_d = DATA_IN;
        4'd1:    faddr_hi_d = DATA_IN[7:0];
        4'd2:    dest_d     = DATA_IN;
        4'd3:    count_d    = DATA_IN;
        default: ;
      endcase
    end
    if (ctrl_wr && DATA_IN[2]) begin
      done_flag_d = 1'b0;
    end

    // Half-period divider runs only in states that time SCK; WAIT_WR freezes it.
    if (state_q inside {StCsSetup, StCmd, StData, StCsHold}) begin
      div_d = div_wrap ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (go) begin
          if (count_q != 16'd0) begin
            state_d     = StCsSetup;
            cs_n_d      = 1'b0;
            shift_d     = {8'h03, faddr_hi_q, faddr_lo_q};
            rem_d       = count_q;
            waddr_d     = dest_q;
            div_d       = 8'd0;
            bit_d       = 5'd0;
            done_flag_d = 1'b0;
          end else begin
            done_d      = 1'b1;
            done_flag_d = 1'b1;
          end
        end
      end
      StCsSetup: begin
        if (div_wrap) begin
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (div_wrap) begin
          sck_d = ~sck_q;
          // Shift on the falling edge so MOSI is stable across the next rise.
          if (sck_q) begin
            shift_d = {shift_q[30:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (div_wrap) begin
          sck_d = ~sck_q;
          if (!sck_q) begin
            // Bytes arrive MSB-first; the first byte lands in the low half of the word.
            if (bit_q < 5'd8) begin
              rx_d[7:0] = {rx_q[6:0], MISO};
            end else begin
              rx_d[15:8] = {rx_q[14:8], MISO};
            end
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd15) begin
              state_d = StWaitWr;
              bit_d   = 5'd0;
            end
          end
        end
      end
      StWaitWr: begin
        // The 16th rising edge is followed by a falling edge on entry; SCK then stays low.
        sck_d = 1'b0;
        if (flash_dma_wready) begin
          rem_d   = rem_q - 16'd1;
          waddr_d = waddr_q + 16'd1;
          div_d   = 8'd0;
          state_d = (rem_q != 16'd1) ? StData : StCsHold;
        end
      end
      StCsHold: begin
        if (div_wrap) begin
          state_d     = StIdle;
          cs_n_d      = 1'b1;
          done_d      = 1'b1;
          done_flag_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && busy) begin
      state_d     = StIdle;
      cs_n_d      = 1'b1;
      sck_d       = 1'b0;
      shift_d     = 32'd0;
      div_d       = 8'd0;
      bit_d       = 5'd0;
      done_d      = 1'b1;
      done_flag_d = 1'b1;
    end

    case (ADDRESS)
      4'd0:    rdata_d = faddr_lo_q;
      4'd1:    rdata_d = {8'h00, faddr_hi_q};
      4'd2:    rdata_d = dest_q;
      4'd3:    rdata_d = count_q;
      4'd4:    rdata_d = {14'd0, done_flag_q, busy};
      default: rdata_d = 16'h0000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      faddr_lo_q  <= 16'd0;
      faddr_hi_q  <= 8'd0;
      dest_q      <= 16'd0;
      count_q     <= 16'd0;
      done_flag_q <= 1'b0;
      done_q      <= 1'b0;
      rem_q       <= 16'd0;
      waddr_q     <= 16'd0;
      shift_q     <= 32'd0;
      rx_q        <= 16'd0;
      bit_q       <= 5'd0;
      div_q       <= 8'd0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      rdata_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      faddr_lo_q  <= faddr_lo_d;
      faddr_hi_q  <= faddr_hi_d;
      dest_q      <= dest_d;
      count_q     <= count_d;
      done_flag_q <= done_flag_d;
      done_q      <= done_d;
      rem_q       <= rem_d;
      waddr_q     <= waddr_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      rdata_q     <= rdata_d;
    end
  end

  assign SCK               = sck_q;
  assign MOSI              = shift_q[31];
  assign CS_N              = cs_n_q;
  assign flash_dma_wvalid  = (state_q == StWaitWr);
  assign flash_dma_address = waddr_q;
  assign flash_dma_data    = rx_q;
  assign DONE              = done_q;
  assign DATA_OUT          = rdata_q;

endmodule

// File: tb/tb_spi_flash_dma.sv
// Testbench for spi_flash_dma: behavioural SPI flash, write-channel scoreboard and
// directed register-level scenarios.
module tb_spi_flash_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  address = 4'd0;
  logic [15:0] data_in = 16'd0;
  logic [15:0] data_out;
  logic        wr = 1'b0;
  logic        sck, mosi, cs_n, wvalid, done;
  logic        miso = 1'b0;
  logic        wready = 1'b0;
  logic [15:0] waddr, wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_flash_dma #(.CLK_DIV(1)) dut (
    .CLK               (clk),
    .RST               (rst),
    .ADDRESS           (address),
    .DATA_IN           (data_in),
    .DATA_OUT          (data_out),
    .WR                (wr),
    .SCK               (sck),
    .MOSI              (mosi),
    .MISO              (miso),
    .CS_N              (cs_n),
    .flash_dma_wvalid  (wvalid),
    .flash_dma_wready  (wready),
    .flash_dma_address (waddr),
    .flash_dma_data    (wdata),
    .DONE              (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flash model: 256-byte image addressed by the low byte of the command address.
  logic [7:0]  mem [256];
  logic [31:0] cmd_sr = 32'd0;
  int          rise_n = 0;
  int          out_idx = 0;

  always @(negedge cs_n) begin
    rise_n  = 0;
    out_idx = 0;
  end

  always @(posedge sck) begin
    if (!cs_n) begin
      if (rise_n < 32) cmd_sr = {cmd_sr[30:0], mosi};
      rise_n++;
    end
  end

  always @(negedge sck) begin
    logic [7:0] b;
    if (!cs_n && rise_n >= 32) begin
      b       = mem[8'(cmd_sr[7:0] + 8'(out_idx / 8))];
      miso    = b[7 - (out_idx % 8)];
      out_idx++;
    end
  end

  // Scoreboard and event counters, sampled away from the active edge.
  logic [31:0] sb_q [$];
  int   n_writes = 0, n_done = 0, n_sck_rise = 0, n_cs_fall = 0;
  logic sck_p = 1'b0, cs_p = 1'b1;

  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst) begin
      if (wvalid && wready) begin
        n_writes++;
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_wr", 32'(sb_q.size()), 32'd1);
        end else begin
          exp = sb_q.pop_front();
          check_eq("wr_addr", 32'(waddr), 32'(exp[31:16]));
          check_eq("wr_data", 32'(wdata), 32'(exp[15:0]));
        end
      end
      if (done) n_done++;
      if (sck && !sck_p) n_sck_rise++;
      if (!cs_n && cs_p) n_cs_fall++;
    end
    sck_p = sck;
    cs_p  = cs_n;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [15:0] d);
    address = a;
    data_in = d;
    wr      = 1'b1;
    tick();
    wr      = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [15:0] d);
    address = a;
    tick();
    d = data_out;
  endtask

  task automatic program_regs(input logic [23:0] fa, input logic [15:0] dst,
                              input logic [15:0] cnt);
    reg_write(4'd0, fa[15:0]);
    reg_write(4'd1, {8'h00, fa[23:16]});
    reg_write(4'd2, dst);
    reg_write(4'd3, cnt);
  endtask

  task automatic push_expected(input logic [23:0] fa, input logic [15:0] dst, input int cnt);
    logic [7:0]  lo, hi;
    logic [15:0] a;
    for (int k = 0; k < cnt; k++) begin
      lo = mem[8'(fa[7:0] + 8'(2 * k))];
      hi = mem[8'(fa[7:0] + 8'(2 * k + 1))];
      a  = 16'(dst + 16'(k));
      sb_q.push_back({a, hi, lo});
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int i = 0;
    while (n_done < target && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, 32'(n_done), 32'(target));
  endtask

  initial begin
    logic [15:0] rd, a0, d0w;
    int d0, w0, c0, r0, i;
    logic stable;

    for (int k = 0; k < 256; k++) mem[k] = 8'(k * 37 + 11);
    mem[8'h40] = 8'h11;
    mem[8'h41] = 8'h22;
    mem[8'h42] = 8'h33;
    mem[8'h43] = 8'h44;

    // Reset state
    tick(3);
    check_eq("rst_sck", 32'(sck), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_wvalid", 32'(wvalid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_waddr", 32'(waddr), 32'd0);
    check_eq("rst_wdata", 32'(wdata), 32'd0);
    check_eq("rst_dout", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      reg_read(4'(k), rd);
      check_eq($sformatf("rst_reg%0d", k), 32'(rd), 32'd0);
    end

    // Basic two-word transfer
    program_regs(24'h012340, 16'h1000, 16'd2);
    reg_read(4'd0, rd); check_eq("rd_faddr_lo", 32'(rd), 32'h2340);
    reg_read(4'd1, rd); check_eq("rd_faddr_hi", 32'(rd), 32'h0001);
    reg_read(4'd2, rd); check_eq("rd_dest", 32'(rd), 32'h1000);
    reg_read(4'd3, rd); check_eq("rd_count", 32'(rd), 32'h0002);
    reg_read(4'd9, rd); check_eq("rd_unused", 32'(rd), 32'h0000);
    wready = 1'b1;
    sb_q.push_back({16'h1000, 16'h2211});
    sb_q.push_back({16'h1001, 16'h4433});
    d0 = n_done; w0 = n_writes;
    reg_write(4'd4, 16'h0001);
    check_eq("go_cs_low", 32'(cs_n), 32'd0);
    check_eq("go_mosi_first", 32'(mosi), 32'd0);
    reg_read(4'd4, rd); check_eq("busy_status", 32'(rd), 32'h0001);
    wait_done(d0 + 1, 2000, "basic_done");
    check_eq("basic_cmd", cmd_sr, 32'h03012340);
    check_eq("basic_writes", 32'(n_writes - w0), 32'd2);
    check_eq("basic_sb_empty", 32'(sb_q.size()), 32'd0);
    tick(3);
    check_eq("basic_one_done", 32'(n_done), 32'(d0 + 1));
    check_eq("basic_cs_high", 32'(cs_n), 32'd1);
    reg_read(4'd4, rd); check_eq("basic_status", 32'(rd), 32'h0002);
    reg_write(4'd4, 16'h0004);
    reg_read(4'd4, rd); check_eq("clr_done", 32'(rd), 32'h0000);

    // Back-pressure on the first word
    wready = 1'b0;
    sb_q.push_back({16'h1000, 16'h2211});
    sb_q.push_back({16'h1001, 16'h4433});
    d0 = n_done;
    reg_write(4'd4, 16'h0001);
    i = 0;
    while (!wvalid && i < 2000) begin tick(); i++; end
    check_eq("stall_wvalid", 32'(wvalid), 32'd1);
    tick(2);
    a0 = waddr; d0w = wdata; r0 = n_sck_rise; stable = 1'b1;
    repeat (18) begin
      tick();
      if (waddr !== a0 || wdata !== d0w || wvalid !== 1'b1 || sck !== 1'b0) stable = 1'b0;
    end
    check_eq("stall_stable", 32'(stable), 32'd1);
    check_eq("stall_no_sck", 32'(n_sck_rise), 32'(r0));
    check_eq("stall_addr", 32'(a0), 32'h1000);
    check_eq("stall_data", 32'(d0w), 32'h2211);
    wready = 1'b1;
    wait_done(d0 + 1, 2000, "stall_done");
    check_eq("stall_sb_empty", 32'(sb_q.size()), 32'd0);

    // Destination address wrap
    program_regs(24'h000010, 16'hFFFF, 16'd2);
    push_expected(24'h000010, 16'hFFFF, 2);
    d0 = n_done;
    reg_write(4'd4, 16'h0001);
    wait_done(d0 + 1, 2000, "wrap_done");
    check_eq("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    // Abort during the command phase
    program_regs(24'h000020, 16'h2000, 16'd3);
    d0 = n_done; w0 = n_writes;
    reg_write(4'd4, 16'h0001);
    tick(20);
    check_eq("abort_pre_cs", 32'(cs_n), 32'd0);
    reg_write(4'd4, 16'h0002);
    check_eq("abort_cs_n", 32'(cs_n), 32'd1);
    check_eq("abort_wvalid", 32'(wvalid), 32'd0);
    check_eq("abort_sck", 32'(sck), 32'd0);
    check_eq("abort_done", 32'(done), 32'd1);
    tick(200);
    check_eq("abort_no_wr", 32'(n_writes), 32'(w0));
    check_eq("abort_one_done", 32'(n_done), 32'(d0 + 1));
    reg_read(4'd4, rd); check_eq("abort_status", 32'(rd), 32'h0002);
    program_regs(24'h000030, 16'h3000, 16'd1);
    push_expected(24'h000030, 16'h3000, 1);
    d0 = n_done;
    reg_write(4'd4, 16'h0001);
    wait_done(d0 + 1, 2000, "post_abort_done");
    check_eq("post_abort_sb", 32'(sb_q.size()), 32'd0);

    // COUNT=0 GO
    reg_write(4'd3, 16'd0);
    c0 = n_cs_fall; d0 = n_done;
    reg_write(4'd4, 16'h0001);
    check_eq("zero_done", 32'(done), 32'd1);
    tick(10);
    check_eq("zero_no_cs", 32'(n_cs_fall), 32'(c0));
    check_eq("zero_one_done", 32'(n_done), 32'(d0 + 1));
    reg_read(4'd4, rd); check_eq("zero_status", 32'(rd), 32'h0002);

    // GO and FADDR write while BUSY
    program_regs(24'h000050, 16'h5000, 16'd1);
    push_expected(24'h000050, 16'h5000, 1);
    d0 = n_done; w0 = n_writes;
    reg_write(4'd4, 16'h0001);
    tick(5);
    reg_write(4'd0, 16'hBEEF);
    reg_write(4'd4, 16'h0001);
    reg_read(4'd0, rd); check_eq("busy_faddr_kept", 32'(rd), 32'h0050);
    wait_done(d0 + 1, 2000, "busy_done");
    check_eq("busy_cmd", cmd_sr, 32'h03000050);
    tick(100);
    check_eq("busy_one_done", 32'(n_done), 32'(d0 + 1));
    check_eq("busy_writes", 32'(n_writes - w0), 32'd1);
    check_eq("busy_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-transfer
    reg_write(4'd4, 16'h0001);
    tick(30);
    rst = 1'b1;
    tick();
    check_eq("midrst_cs_n", 32'(cs_n), 32'd1);
    check_eq("midrst_sck", 32'(sck), 32'd0);
    rst = 1'b0;
    reg_read(4'd2, rd); check_eq("midrst_dest", 32'(rd), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
